rob_commit_controller: RTL and testbench

- Sequences in-order retirement at the head of the reorder buffer.
- Each cycle it inspects the head entry and decides what retirement needs:
  - register write-back to the register file (RF);
  - store hand-off to the load/store buffer (LSB), with a completion handshake;
  - branch-mispredict flush with a PC redirect;
  - halt.
- It then pops the head. The ROB storage is unchanged; this block is the ROB's commit-side controller.

---
 rtl/rob_commit_controller.sv | 162 ++++++++++++++++
 tb/tb_rob_commit_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_controller.sv
// Commit-side controller for the reorder buffer: retires the head entry in order,
// driving RF write-back, store hand-off, mispredict flush and halt.
module rob_commit_controller #(
  parameter int unsigned ROB_SIZE_WIDTH = 3,
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_CNT_WIDTH  = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_empty,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  input  logic                      head_ready,
  input  logic [1:0]                head_type,
  input  logic [REG_CNT_WIDTH-1:0]  head_rd,
  input  logic [XLEN-1:0]           head_val,
  input  logic                      head_jump_pred,
  input  logic                      head_jump_taken,
  input  logic [XLEN-1:0]           head_addr,
  input  logic                      store_done,
  output logic                      rob_pop,
  output logic                      rf_wr_en,
  output logic [REG_CNT_WIDTH-1:0]  rf_wr_rd,
  output logic [XLEN-1:0]           rf_wr_val,
  output logic [ROB_SIZE_WIDTH-1:0] rf_wr_rob_id,
  output logic                      store_req,
  output logic [ROB_SIZE_WIDTH-1:0] store_rob_id,
  output logic                      flush,
  output logic [XLEN-1:0]           flush_pc,
  output logic                      halted,
  output logic [31:0]               commit_cnt
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] TYPE_REG    = 2'b00;
  localparam logic [1:0] TYPE_STORE  = 2'b01;
  localparam logic [1:0] TYPE_BRANCH = 2'b10;
  localparam logic [1:0] TYPE_HALT   = 2'b11;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      rob_pop_d;
  logic                      rf_wr_en_d;
  logic [REG_CNT_WIDTH-1:0]  rf_wr_rd_d;
  logic [XLEN-1:0]           rf_wr_val_d;
  logic [ROB_SIZE_WIDTH-1:0] rf_wr_rob_id_d;
  logic                      store_req_d;
  logic [ROB_SIZE_WIDTH-1:0] store_rob_id_d;
  logic                      flush_d;
  logic [XLEN-1:0]           flush_pc_d;
  logic                      halted_d;
  logic [CNT_W-1:0]          commit_cnt_d;
  logic                      commit_c;

  // A pop still registered means the head inputs are stale this cycle.
  assign commit_c = !rob_empty && head_ready && !rob_pop;

  // State and output registers; rdy_in low freezes everything, reset wins.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= RUN;
      rob_pop      <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_wr_rd     <= '0;
      rf_wr_val    <= '0;
      rf_wr_rob_id <= '0;
      store_req    <= 1'b0;
      store_rob_id <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      halted       <= 1'b0;
      commit_cnt   <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      rob_pop      <= rob_pop_d;
      rf_wr_en     <= rf_wr_en_d;
      rf_wr_rd     <= rf_wr_rd_d;
      rf_wr_val    <= rf_wr_val_d;
      rf_wr_rob_id <= rf_wr_rob_id_d;
      store_req    <= store_req_d;
      store_rob_id <= store_rob_id_d;
      flush        <= flush_d;
      flush_pc     <= flush_pc_d;
      halted       <= halted_d;
      commit_cnt   <= commit_cnt_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d        = state_q;
    rob_pop_d      = 1'b0;
    rf_wr_en_d     = 1'b0;
    flush_d        = 1'b0;
    rf_wr_rd_d     = rf_wr_rd;
    rf_wr_val_d    = rf_wr_val;
    rf_wr_rob_id_d = rf_wr_rob_id;
    store_req_d    = store_req;
    store_rob_id_d = store_rob_id;
    flush_pc_d     = flush_pc;
    halted_d       = halted;
    commit_cnt_d   = commit_cnt;

    case (state_q)
      RUN: begin
        if (commit_c) begin
          case (head_type)
            TYPE_REG: begin
              rob_pop_d      = 1'b1;
              rf_wr_en_d     = 1'b1;
              rf_wr_rd_d     = head_rd;
              rf_wr_val_d    = head_val;
              rf_wr_rob_id_d = rob_head_id;
            end
            TYPE_STORE: begin
              store_req_d    = 1'b1;
              store_rob_id_d = rob_head_id;
              state_d        = STORE_WAIT;
            end
            TYPE_BRANCH: begin
              rob_pop_d = 1'b1;
              if (head_jump_pred != head_jump_taken) begin
                flush_d    = 1'b1;
                flush_pc_d = head_addr;
              end
            end
            TYPE_HALT: begin
              rob_pop_d = 1'b1;
              halted_d  = 1'b1;
              state_d   = HALTED;
            end
            default: ;
          endcase
        end
      end
      STORE_WAIT: begin
        if (store_done) begin
          store_req_d = 1'b0;
          rob_pop_d   = 1'b1;
          state_d     = RUN;
        end
      end
      HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rob_pop_d) begin
      commit_cnt_d = commit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rob_commit_controller.sv
// Bench for rob_commit_controller: directed vector table with hand-derived
// expectations, then random stimulus against a retirement-rule reference model.
module tb_rob_commit_controller;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_empty, head_ready;
  logic [2:0]  rob_head_id;
  logic [1:0]  head_type;
  logic [4:0]  head_rd;
  logic [31:0] head_val, head_addr;
  logic        head_jump_pred, head_jump_taken, store_done;
  logic        rob_pop, rf_wr_en, store_req, flush, halted;
  logic [4:0]  rf_wr_rd;
  logic [31:0] rf_wr_val, flush_pc, commit_cnt;
  logic [2:0]  rf_wr_rob_id, store_rob_id;

  rob_commit_controller #(.ROB_SIZE_WIDTH(3), .XLEN(32), .REG_CNT_WIDTH(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_empty(rob_empty),
    .rob_head_id(rob_head_id), .head_ready(head_ready), .head_type(head_type),
    .head_rd(head_rd), .head_val(head_val), .head_jump_pred(head_jump_pred),
    .head_jump_taken(head_jump_taken), .head_addr(head_addr), .store_done(store_done),
    .rob_pop(rob_pop), .rf_wr_en(rf_wr_en), .rf_wr_rd(rf_wr_rd), .rf_wr_val(rf_wr_val),
    .rf_wr_rob_id(rf_wr_rob_id), .store_req(store_req), .store_rob_id(store_rob_id),
    .flush(flush), .flush_pc(flush_pc), .halted(halted), .commit_cnt(commit_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, rdy, empty, ready;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        pred, taken;
    logic [31:0] addr;
    logic [2:0]  id;
    logic        sdone;
    logic        e_pop, e_wr, e_sreq, e_flush, e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural view of the last retirement outcome.
  logic        m_pop, m_wr, m_sreq, m_flush, m_halt, m_waiting;
  logic [4:0]  m_rd;
  logic [31:0] m_val, m_fpc, m_cnt;
  logic [2:0]  m_id, m_sid;

  function automatic vec_t mk(input logic rst, rdy, empty, ready, input logic [1:0] typ,
                              input logic [4:0] rd, input logic [31:0] val,
                              input logic pred, taken, input logic [31:0] addr,
                              input logic [2:0] id, input logic sdone,
                              input logic e_pop, e_wr, e_sreq, e_flush, e_halt,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.empty = empty; v.ready = ready; v.typ = typ;
    v.rd = rd; v.val = val; v.pred = pred; v.taken = taken; v.addr = addr;
    v.id = id; v.sdone = sdone; v.e_pop = e_pop; v.e_wr = e_wr; v.e_sreq = e_sreq;
    v.e_flush = e_flush; v.e_halt = e_halt; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pop = 0; m_wr = 0; m_sreq = 0; m_flush = 0; m_halt = 0; m_waiting = 0;
    m_rd = 0; m_val = 0; m_fpc = 0; m_cnt = 0; m_id = 0; m_sid = 0;
  endtask

  // One clock edge of retirement rules applied to the inputs presented at it.
  task automatic model_step(input vec_t v);
    logic stale;
    if (v.rst) begin
      model_reset();
    end else if (v.rdy) begin
      stale   = m_pop;
      m_pop   = 0;
      m_wr    = 0;
      m_flush = 0;
      if (m_halt) begin
      end else if (m_waiting) begin
        if (v.sdone) begin
          m_waiting = 0; m_sreq = 0; m_pop = 1;
        end
      end else if (!v.empty && v.ready && !stale) begin
        if (v.typ == 2'b00) begin
          m_pop = 1; m_wr = 1; m_rd = v.rd; m_val = v.val; m_id = v.id;
        end else if (v.typ == 2'b01) begin
          m_waiting = 1; m_sreq = 1; m_sid = v.id;
        end else if (v.typ == 2'b10) begin
          m_pop = 1;
          if (v.pred != v.taken) begin
            m_flush = 1; m_fpc = v.addr;
          end
        end else begin
          m_pop = 1; m_halt = 1;
        end
      end
      if (m_pop) m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic drive(input vec_t v);
    rst_in = v.rst; rdy_in = v.rdy; rob_empty = v.empty; head_ready = v.ready;
    head_type = v.typ; head_rd = v.rd; head_val = v.val; head_jump_pred = v.pred;
    head_jump_taken = v.taken; head_addr = v.addr; rob_head_id = v.id; store_done = v.sdone;
  endtask

  task automatic compare_model();
    check("rob_pop", 32'(rob_pop), 32'(m_pop));
    check("rf_wr_en", 32'(rf_wr_en), 32'(m_wr));
    check("rf_wr_rd", 32'(rf_wr_rd), 32'(m_rd));
    check("rf_wr_val", rf_wr_val, m_val);
    check("rf_wr_rob_id", 32'(rf_wr_rob_id), 32'(m_id));
    check("store_req", 32'(store_req), 32'(m_sreq));
    check("store_rob_id", 32'(store_rob_id), 32'(m_sid));
    check("flush", 32'(flush), 32'(m_flush));
    check("flush_pc", flush_pc, m_fpc);
    check("halted", 32'(halted), 32'(m_halt));
    check("commit_cnt", commit_cnt, m_cnt);
  endtask

  task automatic apply(input vec_t v);
    drive(v);
    @(posedge clk_in);
    model_step(v);
    #1;
    compare_model();
  endtask

  initial begin
    vec_t v;
    model_reset();
    // rst rdy emp rdy typ rd val pred tk addr id sd | pop wr sreq fl halt cnt
    vecs.push_back(mk(1,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd0));
    vecs.push_back(mk(1,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd0));
    vecs.push_back(mk(0,1,0,0,2'd0,5'd9,32'h55,0,0,32'h0,3'd1,0, 0,0,0,0,0,32'd0));
    // REG commits recur every second cycle while the head stays ready
    vecs.push_back(mk(0,1,0,1,2'd0,5'd5,32'hDEADBEEF,0,0,32'h0,3'd3,0, 1,1,0,0,0,32'd1));
    vecs.push_back(mk(0,1,0,1,2'd0,5'd5,32'hDEADBEEF,0,0,32'h0,3'd3,0, 0,0,0,0,0,32'd1));
    vecs.push_back(mk(0,1,0,1,2'd0,5'd5,32'hDEADBEEF,0,0,32'h0,3'd3,0, 1,1,0,0,0,32'd2));
    vecs.push_back(mk(0,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,1, 0,0,0,0,0,32'd2));
    // store handshake
    vecs.push_back(mk(0,1,0,1,2'd1,5'd0,32'h0,0,0,32'h0,3'd6,0, 0,0,1,0,0,32'd2));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,0,1,2'd1,5'd0,32'h0,0,0,32'h0,3'd6,0, 0,0,1,0,0,32'd2));
    vecs.push_back(mk(0,1,0,1,2'd1,5'd0,32'h0,0,0,32'h0,3'd6,1, 1,0,0,0,0,32'd3));
    vecs.push_back(mk(0,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd3));
    // branches: mispredict then correct prediction
    vecs.push_back(mk(0,1,0,1,2'd2,5'd0,32'h0,1,0,32'h1000,3'd4,0, 1,0,0,1,0,32'd4));
    vecs.push_back(mk(0,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd4));
    vecs.push_back(mk(0,1,0,1,2'd2,5'd0,32'h0,1,1,32'h2000,3'd5,0, 1,0,0,0,0,32'd5));
    vecs.push_back(mk(0,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd5));
    // freeze mid-store, then reset with rdy_in low
    vecs.push_back(mk(0,1,0,1,2'd1,5'd0,32'h0,0,0,32'h0,3'd2,0, 0,0,1,0,0,32'd5));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,0,1,2'd1,5'd0,32'h0,0,0,32'h0,3'd2,1, 0,0,1,0,0,32'd5));
    vecs.push_back(mk(1,0,0,1,2'd1,5'd0,32'h0,0,0,32'h0,3'd2,1, 0,0,0,0,0,32'd0));
    // freeze holds a pulse
    vecs.push_back(mk(0,1,0,1,2'd0,5'd7,32'h12345678,0,0,32'h0,3'd7,0, 1,1,0,0,0,32'd1));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(0,0,0,1,2'd0,5'd7,32'h12345678,0,0,32'h0,3'd7,0, 1,1,0,0,0,32'd1));
    vecs.push_back(mk(0,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd1));
    // halt is terminal until reset
    vecs.push_back(mk(0,1,0,1,2'd3,5'd0,32'h0,0,0,32'h0,3'd0,0, 1,0,0,0,1,32'd2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,1,0,1,2'd0,5'd3,32'h77,0,0,32'h0,3'd1,1, 0,0,0,0,1,32'd2));
    vecs.push_back(mk(1,1,1,0,2'd0,5'd0,32'h0,0,0,32'h0,3'd0,0, 0,0,0,0,0,32'd0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check("vec_pop", 32'(rob_pop), 32'(vecs[i].e_pop));
      check("vec_wr_en", 32'(rf_wr_en), 32'(vecs[i].e_wr));
      check("vec_store_req", 32'(store_req), 32'(vecs[i].e_sreq));
      check("vec_flush", 32'(flush), 32'(vecs[i].e_flush));
      check("vec_halted", 32'(halted), 32'(vecs[i].e_halt));
      check("vec_cnt", commit_cnt, vecs[i].e_cnt);
      if (vecs[i].e_wr) begin
        check("vec_wr_rd", 32'(rf_wr_rd), 32'(vecs[i].rd));
        check("vec_wr_val", rf_wr_val, vecs[i].val);
        check("vec_wr_id", 32'(rf_wr_rob_id), 32'(vecs[i].id));
      end
      if (vecs[i].e_sreq) check("vec_store_id", 32'(store_rob_id), 32'(vecs[i].id));
      if (vecs[i].e_flush) check("vec_flush_pc", flush_pc, vecs[i].addr);
    end

    // random traffic, including wrapping head ids and rare resets/halts
    for (int n = 0; n < 4000; n++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.rdy   = ($urandom_range(0, 99) < 85);
      v.empty = ($urandom_range(0, 99) < 25);
      v.ready = ($urandom_range(0, 99) < 70);
      v.typ   = ($urandom_range(0, 39) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      v.rd    = 5'($urandom);
      v.val   = $urandom;
      v.pred  = 1'($urandom);
      v.taken = 1'($urandom);
      v.addr  = $urandom;
      v.id    = 3'($urandom);
      v.sdone = ($urandom_range(0, 99) < 30);
      v.e_pop = 0; v.e_wr = 0; v.e_sreq = 0; v.e_flush = 0; v.e_halt = 0; v.e_cnt = 0;
      apply(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
